obstacle_collide: RTL and testbench



---
 rtl/obstacle_pkg.sv | 25 ++
 rtl/obstacle_score.sv | 28 ++
 rtl/obstacle_collide.sv | 147 ++++++++++++++
 tb/tb_obstacle_collide.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Package: obstacle_pkg
// Shared types and default geometry for the obstacle game. The draw stage
// imports the same geometry, so the two always agree on where things are.
//   state_t        : game FSM state (IDLE, RUN, HIT)
//   *_DEF          : default screen / player / obstacle geometry
//   STEP_MAX       : largest per-tick step the mover can apply
package obstacle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HIT
    } state_t;

    localparam int SCREEN_W_DEF = 640;
    localparam int PLAYER_X_DEF = 100;
    localparam int PLAYER_W_DEF = 20;
    localparam int OBS_W_DEF    = 20;
    localparam int OBS_H_DEF    = 40;
    localparam int SPEED_DEF    = 4;
    localparam int SCORE_W_DEF  = 8;

    localparam int STEP_MAX     = 15;

endpackage

// File: rtl/obstacle_score.sv
// Module: obstacle_score
// Saturating score counter. Clear has priority over increment; once the
// count reaches all-ones further increments are dropped.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high reset
//   clr    in  load zero (new game)
//   inc    in  add one (obstacle cleared)
//   score  out current count, SCORE_W bits
module obstacle_score #(
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] score
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            score <= '0;
        end else if (inc && (score != '1)) begin
            score <= score + SCORE_W'(1);
        end
    end

endmodule

// File: rtl/obstacle_collide.sv
// Module: obstacle_collide
// Scrolls a single obstacle right-to-left on each frame tick, tests it
// against the player's column and jump height, latches game-over on a hit
// and counts obstacles cleared.
// Optional feature macro: OBSTACLE_SPEEDUP_EN -- when defined the per-tick
// step grows with the score (SPEED + score/8, capped at 15); otherwise the
// step is the constant SPEED.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   tick       in   one-cycle frame strobe; motion only happens on tick
//   start      in   level; starts a game from IDLE or restarts from HIT
//   jump_h     in   player height above ground (10 bits, from jump_logic)
//   obs_x      out  obstacle left edge (10 bits)
//   score      out  obstacles cleared this game (SCORE_W bits)
//   running    out  high while in RUN
//   game_over  out  high while in HIT
//   cleared    out  one-cycle pulse when an obstacle wraps without a hit
module obstacle_collide
    import obstacle_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int PLAYER_X = PLAYER_X_DEF,
    parameter int PLAYER_W = PLAYER_W_DEF,
    parameter int OBS_W    = OBS_W_DEF,
    parameter int OBS_H    = OBS_H_DEF,
    parameter int SPEED    = SPEED_DEF,
    parameter int SCORE_W  = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic [9:0]         jump_h,
    output logic [9:0]         obs_x,
    output logic [SCORE_W-1:0] score,
    output logic               running,
    output logic               game_over,
    output logic               cleared
);

    // Overlap bounds are 11 bits so obs_x + OBS_W cannot wrap at the right edge.
    localparam logic [10:0] COL_LEFT  = 11'(PLAYER_X);
    localparam logic [10:0] COL_RIGHT = 11'(PLAYER_X + PLAYER_W);
    localparam logic [10:0] OBS_W11   = 11'(OBS_W);
    localparam logic [9:0]  X_START   = 10'(SCREEN_W - 1);
    localparam logic [9:0]  H_CLEAR   = 10'(OBS_H);

    state_t      state;
    logic        hit;
    logic        wrap;
    logic [3:0]  step;
    logic        score_clr;
    logic        score_inc;

    // ------------------------------------------------------------------
    // Step size
    // ------------------------------------------------------------------
`ifdef OBSTACLE_SPEEDUP_EN
    // Wide enough that SPEED + score/8 never overflows before the cap.
    localparam int SUM_W = (SCORE_W > 4) ? SCORE_W + 1 : 5;
    logic [SUM_W-1:0] step_sum;

    always_comb begin
        step_sum = SUM_W'(SPEED) + SUM_W'(score >> 3);
        step     = (step_sum > SUM_W'(STEP_MAX)) ? 4'(STEP_MAX) : step_sum[3:0];
    end
`else
    assign step = 4'(SPEED);
`endif

    // ------------------------------------------------------------------
    // Collision and wrap tests (every cycle, not only on tick)
    // ------------------------------------------------------------------
    always_comb begin
        hit  = (state == RUN)
            && ({1'b0, obs_x} < COL_RIGHT)
            && (({1'b0, obs_x} + OBS_W11) > COL_LEFT)
            && (jump_h < H_CLEAR);
        wrap = (obs_x < 10'(step));
    end

    // A hit in the same cycle as a wrap suppresses the score increment.
    assign score_clr = (state != RUN) && start;
    assign score_inc = (state == RUN) && !hit && tick && wrap;

    obstacle_score #(
        .SCORE_W (SCORE_W)
    ) u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .score (score)
    );

    // ------------------------------------------------------------------
    // FSM, mover and registered status outputs
    // ------------------------------------------------------------------
    // NOTE: state and outputs use non-blocking assignments so every register
    // samples the pre-edge values; blocking here would let later statements
    // see half-updated state and simulate differently from the netlist.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            obs_x     <= X_START;
            running   <= 1'b0;
            game_over <= 1'b0;
            cleared   <= 1'b0;
        end else begin
            cleared <= 1'b0;
            case (state)
                IDLE, HIT: begin
                    // Obstacle and score hold in HIT so the draw stage can
                    // show where the collision happened.
                    if (start) begin
                        state     <= RUN;
                        obs_x     <= X_START;
                        running   <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                RUN: begin
                    if (hit) begin
                        state     <= HIT;
                        running   <= 1'b0;
                        game_over <= 1'b1;
                    end else if (tick) begin
                        if (wrap) begin
                            obs_x   <= X_START;
                            cleared <= 1'b1;
                        end else begin
                            obs_x <= obs_x - 10'(step);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    obs_x     <= X_START;
                    running   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_collide.sv
// Bench for obstacle_collide. Two instances share stimulus: one with the
// default 8-bit score, one with a 2-bit score to exercise saturation. A
// behavioural game model predicts both every cycle; a few literal values
// from hand calculation pin the model.
module tb_obstacle_collide;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       start;
    logic [9:0] jump_h;

    logic [9:0] a_x,  b_x;
    logic [7:0] a_score;
    logic [1:0] b_score;
    logic       a_run, a_over, a_clr;
    logic       b_run, b_over, b_clr;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    obstacle_collide #(.SCORE_W(8)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .jump_h(jump_h),
        .obs_x(a_x), .score(a_score), .running(a_run), .game_over(a_over),
        .cleared(a_clr)
    );

    obstacle_collide #(.SCORE_W(2)) dut_s2 (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .jump_h(jump_h),
        .obs_x(b_x), .score(b_score), .running(b_run), .game_over(b_over),
        .cleared(b_clr)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: is a game in progress, has it ended in a collision,
    // where is the obstacle, what is the score, did it just clear one.
    bit m_play[2];
    bit m_over[2];
    bit m_cl[2];
    int m_x[2];
    int m_score[2];
    int m_lim[2] = '{255, 3};

    function automatic int step_of(input int sc);
`ifdef OBSTACLE_SPEEDUP_EN
        int s = 4 + sc / 8;
        return (s > 15) ? 15 : s;
`else
        return 4;
`endif
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit overlap;
            int st;
            overlap = (m_x[i] < 100 + 20) && (m_x[i] + 20 > 100) && (int'(jump_h) < 40);
            st = step_of(m_score[i]);
            m_cl[i] = 1'b0;
            if (reset) begin
                m_play[i] = 1'b0; m_over[i] = 1'b0; m_x[i] = 639; m_score[i] = 0;
            end else if (!m_play[i]) begin
                if (start) begin
                    m_play[i] = 1'b1; m_over[i] = 1'b0; m_x[i] = 639; m_score[i] = 0;
                end
            end else if (overlap) begin
                m_play[i] = 1'b0; m_over[i] = 1'b1;
            end else if (tick) begin
                if (m_x[i] < st) begin
                    m_x[i] = 639; m_cl[i] = 1'b1;
                    if (m_score[i] < m_lim[i]) m_score[i]++;
                end else begin
                    m_x[i] = m_x[i] - st;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("a.obs_x",     int'(a_x),     m_x[0]);
            check("a.score",     int'(a_score), m_score[0]);
            check("a.running",   int'(a_run),   int'(m_play[0]));
            check("a.game_over", int'(a_over),  int'(m_over[0]));
            check("a.cleared",   int'(a_clr),   int'(m_cl[0]));
            check("b.obs_x",     int'(b_x),     m_x[1]);
            check("b.score",     int'(b_score), m_score[1]);
            check("b.running",   int'(b_run),   int'(m_play[1]));
            check("b.game_over", int'(b_over),  int'(m_over[1]));
            check("b.cleared",   int'(b_clr),   int'(m_cl[1]));
        end
    end

    // ---------------- stimulus helpers (called just after a negedge) -----
    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1; @(negedge clk);
            tick = 1'b0; @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; jump_h = 10'd100;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst.obs_x",     int'(a_x),     639);
        check("rst.score",     int'(a_score), 0);
        check("rst.running",   int'(a_run),   0);
        check("rst.game_over", int'(a_over),  0);
        ticks(3);
        check("idle.tick_ignored", int'(a_x), 639);

        // Start, clear one obstacle: 639 -> 3 after 159 ticks, 160th wraps
        pulse_start();
        check("start.running", int'(a_run), 1);
        check("start.obs_x",   int'(a_x),   639);
        ticks(159);
        check("pre_wrap.obs_x", int'(a_x), 3);
        ticks(1);
        check("wrap.obs_x", int'(a_x),     639);
        check("wrap.score", int'(a_score), 1);

        // start while running is ignored
        pulse_start();
        check("run.start_ignored", int'(a_score), 1);

        // Boundary height 40 through the overlap window: no hit
        jump_h = 10'd40;
        ticks(160);
        check("h40.running", int'(a_run),   1);
        check("h40.score",   int'(a_score), 2);

        // Height 30: obstacle reaches 119 after 130 ticks, hit on next edge
        jump_h = 10'd30;
        ticks(130);
        check("h30.game_over", int'(a_over), 1);
        check("h30.obs_x",     int'(a_x),    119);
        ticks(5);
        check("hit.obs_x_hold", int'(a_x),     119);
        check("hit.score_hold", int'(a_score), 2);

        // Restart from HIT
        jump_h = 10'd100;
        pulse_start();
        check("restart.running",   int'(a_run),   1);
        check("restart.game_over", int'(a_over),  0);
        check("restart.obs_x",     int'(a_x),     639);
        check("restart.score",     int'(a_score), 0);

        // Five wraps then 84 ticks: score 5, obs_x 639-336=303; 2-bit score stuck at 3
        ticks(5 * 160 + 84);
        check("mid.obs_x",   int'(a_x),     303);
        check("mid.score",   int'(a_score), 5);
        check("mid.score2",  int'(b_score), 3);

        // Reset mid-game
        reset = 1'b1; @(negedge clk);
        reset = 1'b0;
        check("rst2.obs_x",   int'(a_x),     639);
        check("rst2.score",   int'(a_score), 0);
        check("rst2.running", int'(a_run),   0);
        ticks(4);
        check("rst2.tick_ignored", int'(a_x), 639);

        // Long run: score passes 8 (speed-up region when enabled)
        pulse_start();
        ticks(9 * 160);

        // Ground-level player eventually collides
        jump_h = 10'd0;
        ticks(200);
        check("h0.game_over", int'(a_over), 1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
